inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter NB_DATA, default 32: instruction word width.
REQ-002 Parameter NB_BYTE, default 8: incoming byte width.
REQ-003 Parameter ADDRWIDTH, default 7: instruction-memory address width (128 words).
REQ-004 Parameter HALT_WORD, default 32'hFFFFFFFF: end-of-program word.
REQ-005 clock_i  input  1  single clock, all state on rising edge.
REQ-006 reset_i  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  one-cycle pulse; begins a load at address 0.
REQ-008 rx_data_i  input  NB_BYTE  byte from UART receiver.
REQ-009 rx_valid_i  input  1  one-cycle strobe qualifying rx_data_i.
REQ-010 inst_load_o  output  NB_DATA  assembled word to instruction-memory write port.
REQ-011 wr_addr_o  output  ADDRWIDTH  write address.
REQ-012 en_write_o  output  1  one-cycle write enable.
REQ-013 busy_o  output  1  high in ASSEMBLE or WRITE.
REQ-014 done_o  output  1  high in DONE.
REQ-015 full_err_o  output  1  load ended by memory full, no HALT seen.
REQ-016 inst_count_o  output  ADDRWIDTH+1  words written in current/last load.

Function
REQ-017 FSM states SHALL be IDLE, ASSEMBLE, WRITE, DONE.
REQ-018 IDLE: rx_valid_i ignored; start_i -> ASSEMBLE, byte counter, address and inst_count_o cleared, full_err_o cleared.
REQ-019 ASSEMBLE: each rx_valid_i shifts rx_data_i into a word register, first byte = bits [31:24] (big-endian); fourth byte -> WRITE next cycle.
REQ-020 WRITE (exactly one cycle): en_write_o=1, inst_load_o = assembled word, wr_addr_o = current address; inst_count_o increments on leaving WRITE.
REQ-021 Write latency: en_write_o asserted on the cycle after the clock edge that captured the fourth byte.
REQ-022 inst_load_o and wr_addr_o SHALL remain stable from WRITE until the next WRITE.
REQ-023 From WRITE: word == HALT_WORD -> DONE (HALT word is written); else address == 2^ADDRWIDTH-1 -> DONE with full_err_o=1; else address+1, -> ASSEMBLE.
REQ-024 A rx_valid_i in the WRITE cycle SHALL be captured as byte 0 of the next word (no byte loss).
REQ-025 rx_valid_i in DONE ignored; done_o held until start_i, which restarts exactly as from IDLE.
REQ-026 start_i in ASSEMBLE or WRITE SHALL be ignored.
REQ-027 Address SHALL never wrap; no write beyond 2^ADDRWIDTH-1.
REQ-028 busy_o and done_o never simultaneously high.

Reset
REQ-029 On reset_i low, asynchronously: state=IDLE, all outputs 0, byte counter, word register and address 0.
REQ-030 Reset mid-load SHALL abort with no further en_write_o; partial word discarded.

Structure
REQ-031 State encoding and HALT_WORD default SHALL live in the shared MIPS package.
REQ-032 Byte-to-word shift register MAY be a sub-module byte_packer; FSM stays in inst_loader.

Verification
REQ-033 start, bytes 20 08 00 05, then FF FF FF FF -> writes 0x20080005@0, 0xFFFFFFFF@1, done_o=1, inst_count_o=2, full_err_o=0.
REQ-034 128 non-HALT words -> 128 writes at addresses 0..127, done_o=1, full_err_o=1, no write 129.
REQ-035 rx_valid_i on the WRITE cycle (back-to-back bytes) -> next word assembled correctly, no byte lost.
REQ-036 bytes before start_i and after DONE -> no en_write_o, counters unchanged.
REQ-037 reset_i low after 2 bytes of word 1 -> outputs 0 immediately; new start, 4 bytes -> write at address 0 with only new bytes.
REQ-038 start_i during ASSEMBLE -> ignored, address continues incrementing.

Source files
------------

// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader_pkg
// Description : Shared definitions for the instruction loader: FSM state
//               encoding and the default end-of-program (HALT) word.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

    // Loader FSM states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } loader_state_t;

    // Word that terminates a program image; it is itself written to memory
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader_byte_packer
// Description : Big-endian byte-to-word shifter. Keeps only the bytes already
//               received for the current word; the full word is formed
//               combinationally with the byte presented this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader_byte_packer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               clear,
    input  logic               shift,
    input  logic [NB_BYTE-1:0] byte_in,
    output logic [NB_DATA-1:0] word_next
);

    localparam int PART_W = NB_DATA - NB_BYTE;

    logic [PART_W-1:0] partial;

    // Earlier bytes end up in the upper bits: first byte lands in the MSBs
    assign word_next = {partial, byte_in};

    // Partial-word register: cleared at load start, shifts on each accepted byte
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            partial <= '0;
        end else if (clear) begin
            partial <= '0;
        end else if (shift) begin
            partial <= word_next[PART_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Loads a program received byte-wise from a UART into the
//               instruction memory. Bytes are packed big-endian into words,
//               each word is written for one cycle at an incrementing address,
//               and loading stops at the HALT word or when memory is full.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 ADDRWIDTH = 7,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [NB_BYTE-1:0]   rx_data_i,
    input  logic                 rx_valid_i,
    output logic [NB_DATA-1:0]   inst_load_o,
    output logic [ADDRWIDTH-1:0] wr_addr_o,
    output logic                 en_write_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 full_err_o,
    output logic [ADDRWIDTH:0]   inst_count_o
);

    localparam int                   BYTES     = NB_DATA / NB_BYTE;
    localparam int                   CNT_W     = $clog2(BYTES);
    localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDRWIDTH-1:0] ADDR_MAX  = '1;

    loader_state_t        state;
    loader_state_t        next_state;
    logic [CNT_W-1:0]     byte_cnt;
    logic [ADDRWIDTH-1:0] addr;
    logic [NB_DATA-1:0]   word_next;
    logic                 start_load;
    logic                 shift;
    logic                 last_byte;
    logic                 is_halt;
    logic                 at_top;

    // The held output word is the one being written while in WRITE
    assign is_halt    = (inst_load_o == HALT_WORD);
    assign at_top     = (addr == ADDR_MAX);
    assign en_write_o = (state == ST_WRITE);
    assign busy_o     = (state == ST_ASSEMBLE) || (state == ST_WRITE);
    assign done_o     = (state == ST_DONE);

    inst_loader_byte_packer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_packer (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear     (start_load),
        .shift     (shift),
        .byte_in   (rx_data_i),
        .word_next (word_next)
    );

    // State register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a byte arriving during WRITE starts the next word
    always_comb begin
        next_state = state;
        start_load = 1'b0;
        shift      = 1'b0;
        last_byte  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    start_load = 1'b1;
                    next_state = ST_ASSEMBLE;
                end
            end
            ST_ASSEMBLE: begin
                if (rx_valid_i) begin
                    shift = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        last_byte  = 1'b1;
                        next_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (is_halt || at_top) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_ASSEMBLE;
                    shift      = rx_valid_i;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Byte position within the current word; wraps to zero after the last byte
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            byte_cnt <= '0;
        end else if (start_load) begin
            byte_cnt <= '0;
        end else if (shift) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Write address: advances only when another word will follow
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            addr <= '0;
        end else if (start_load) begin
            addr <= '0;
        end else if ((state == ST_WRITE) && (next_state == ST_ASSEMBLE)) begin
            addr <= addr + ADDRWIDTH'(1);
        end
    end

    // Output word/address captured with the last byte and held until the next write
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            inst_load_o <= '0;
            wr_addr_o   <= '0;
        end else if (last_byte) begin
            inst_load_o <= word_next;
            wr_addr_o   <= addr;
        end
    end

    // Word counter and memory-full flag, both updated on leaving WRITE
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            inst_count_o <= '0;
            full_err_o   <= 1'b0;
        end else if (start_load) begin
            inst_count_o <= '0;
            full_err_o   <= 1'b0;
        end else if (state == ST_WRITE) begin
            inst_count_o <= inst_count_o + (ADDRWIDTH+1)'(1);
            if (!is_halt && at_top) begin
                full_err_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_loader
// Description : Self-checking bench for inst_loader. A transaction-level model
//               (byte queue, word list, load flags) predicts every output on
//               every cycle; stimulus mixes directed programs and random bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [31:0] inst_load_o;
    logic [6:0]  wr_addr_o;
    logic        en_write_o;
    logic        busy_o;
    logic        done_o;
    logic        full_err_o;
    logic [7:0]  inst_count_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_active;
    bit          m_done;
    bit          m_full;
    bit          m_write;
    int          m_count;
    int          m_addr;
    logic [31:0] m_word;
    logic [31:0] m_last_word;
    int          m_last_addr;
    logic [7:0]  m_bytes[$];

    inst_loader dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .inst_load_o  (inst_load_o),
        .wr_addr_o    (wr_addr_o),
        .en_write_o   (en_write_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .full_err_o   (full_err_o),
        .inst_count_o (inst_count_o)
    );

    // 100 MHz clock
    always #5 clock_i = ~clock_i;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_full = 0; m_write = 0;
        m_count = 0; m_addr = 0; m_word = '0;
        m_last_word = '0; m_last_addr = 0;
        m_bytes.delete();
    endtask

    // Effect of one clock edge on the loader, from the load rules
    task automatic model_edge(input bit st, input bit v, input logic [7:0] d);
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_done = 0; m_full = 0;
                m_count = 0; m_addr = 0;
                m_bytes.delete();
            end
        end else if (m_write) begin
            m_write = 0;
            m_count++;
            if (m_word == HALT) begin
                m_active = 0; m_done = 1;
            end else if (m_addr == 127) begin
                m_active = 0; m_done = 1; m_full = 1;
            end else begin
                m_addr++;
                if (v) m_bytes.push_back(d);
            end
        end else if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                m_write = 1;
                m_last_word = m_word;
                m_last_addr = m_addr;
            end
        end
    endtask

    task automatic check_outputs();
        chk("en_write", en_write_o, m_write);
        chk("busy", busy_o, m_active);
        chk("done", done_o, m_done);
        chk("full_err", full_err_o, m_full);
        chk("inst_count", inst_count_o, m_count);
        chk("inst_load", inst_load_o, m_last_word);
        chk("wr_addr", wr_addr_o, m_last_addr);
    endtask

    // One clock: drive at negedge, model the posedge, check at the next negedge
    task automatic step(input bit st, input bit v, input logic [7:0] d);
        start_i = st; rx_valid_i = v; rx_data_i = d;
        @(posedge clock_i);
        model_edge(st, v, d);
        @(negedge clock_i);
        start_i = 1'b0; rx_valid_i = 1'b0;
        check_outputs();
    endtask

    // Send a word's four bytes, each preceded by 0..max_gap idle cycles
    task automatic send_word(input logic [31:0] w, input int max_gap, input bit start_noise);
        for (int b = 3; b >= 0; b--) begin
            int gap;
            gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
            step(start_noise && ($urandom_range(0, 5) == 0), 1'b1, w[8*b +: 8]);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == HALT);
        return w;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clock_i);
        chk("reset_en_write", en_write_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_count", inst_count_o, 0);
        chk("reset_inst_load", inst_load_o, 0);
        reset_i = 1'b1;

        // Bytes while idle are ignored
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom));

        // Directed two-word program ending in HALT
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h2008_0005, 2, 1'b0);
        send_word(HALT, 2, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("prog_done", done_o, 1'b1);
        chk("prog_count", inst_count_o, 8'd2);
        chk("prog_full", full_err_o, 1'b0);
        chk("prog_last_word", inst_load_o, HALT);

        // Bytes after DONE are ignored
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));

        // Random program: back-to-back bytes plus stray start pulses mid-load
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) send_word(rand_word(), (i % 3 == 0) ? 0 : 3, 1'b1);
        send_word(HALT, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        chk("rand_count", inst_count_o, 8'd13);

        // Memory full: 128 non-HALT words, then extra bytes that must not write
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 128; i++) send_word(rand_word(), (i % 4 == 0) ? 1 : 0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
        chk("full_flag", full_err_o, 1'b1);
        chk("full_count", inst_count_o, 8'd128);
        chk("full_last_addr", wr_addr_o, 7'd127);

        // Reset mid-word: outputs clear at once, partial bytes discarded
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        #2 reset_i = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_count", inst_count_o, 0);
        chk("arst_inst_load", inst_load_o, 0);
        chk("arst_wr_addr", wr_addr_o, 0);
        chk("arst_full", full_err_o, 1'b0);
        @(negedge clock_i);
        check_outputs();
        reset_i = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h1234_5678, 1, 1'b0);
        chk("post_rst_word", inst_load_o, 32'h1234_5678);
        chk("post_rst_addr", wr_addr_o, 7'd0);
        send_word(HALT, 0, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_done", done_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
